// File: rtl/time_set_ctrl.sv
// time_set_ctrl: walks the user through the set fields of the alarm clock and
// turns up/down button activity into single-cycle count enables for the
// selected field counter, with press-and-hold auto-repeat, idle return to RUN
// and a blink indication for the field being adjusted.
module time_set_ctrl #(
  parameter int unsigned HOLD_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD = 100,
  parameter int unsigned IDLE_TIMEOUT  = 10000,
  parameter int unsigned BLINK_HALF    = 250,
  parameter int unsigned CNT_W         = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] sel,
  output logic       c,
  output logic       cu,
  output logic       cd,
  output logic       setting,
  output logic       blink
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    T_HR  = 3'd1,
    T_MIN = 3'd2,
    A_HR  = 3'd3,
    A_MIN = 3'd4
  } state_t;

  state_t state, state_nx;

  // Previous button samples for edge detection
  logic mode_q, up_q, dn_q;

  // Hold/auto-repeat tracking
  logic             hold_act, hold_act_nx;
  logic             hold_up, hold_up_nx;
  logic             hold_rep, hold_rep_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;

  logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_nx;

  logic [3:0] sel_nx;
  logic       c_nx, cu_nx, cd_nx, setting_nx, blink_nx;

  logic in_set, any_btn, mode_edge, up_only, dn_only, up_edge, dn_edge;
  logic hold_same, hold_hit, step, idle_expire;
  logic [CNT_W-1:0] hold_limit;

  // Decoded button conditions shared by next-state and output logic
  always_comb begin
    in_set      = (state != RUN);
    any_btn     = btn_mode | btn_up | btn_down;
    mode_edge   = btn_mode & ~mode_q;
    up_only     = btn_up & ~btn_down;
    dn_only     = btn_down & ~btn_up;
    up_edge     = up_only & ~up_q;
    dn_edge     = dn_only & ~dn_q;
    hold_same   = hold_up ? up_only : dn_only;
    hold_limit  = hold_rep ? CNT_W'(REPEAT_PERIOD) : CNT_W'(HOLD_DELAY);
    hold_hit    = hold_act & hold_same & (hold_cnt == hold_limit);
    // A mode edge always wins over a step in the same cycle
    step        = in_set & ~mode_edge & (up_edge | dn_edge | hold_hit);
    idle_expire = in_set & ~any_btn & (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: mode edge advances through the fields, idle returns to RUN
  always_comb begin
    state_nx = state;
    if (mode_edge) begin
      case (state)
        RUN:     state_nx = T_HR;
        T_HR:    state_nx = T_MIN;
        T_MIN:   state_nx = A_HR;
        A_HR:    state_nx = A_MIN;
        A_MIN:   state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end else if (idle_expire) begin
      state_nx = RUN;
    end
  end

  // Next values of registered outputs, hold, idle and blink timers
  always_comb begin
    hold_act_nx  = 1'b0;
    hold_up_nx   = hold_up;
    hold_rep_nx  = 1'b0;
    hold_cnt_nx  = '0;
    idle_cnt_nx  = '0;
    blink_cnt_nx = '0;
    blink_nx     = 1'b0;
    sel_nx       = 4'b0000;

    c_nx       = step;
    cu_nx      = step & up_only;
    cd_nx      = step & dn_only;
    setting_nx = (state_nx != RUN);

    case (state_nx)
      T_HR:    sel_nx = 4'b0001;
      T_MIN:   sel_nx = 4'b0010;
      A_HR:    sel_nx = 4'b0100;
      A_MIN:   sel_nx = 4'b1000;
      default: sel_nx = 4'b0000;
    endcase

    // Hold timer: armed by a fresh single-button press, dropped on anything else
    if (in_set && !mode_edge) begin
      if (up_edge || dn_edge) begin
        hold_act_nx = 1'b1;
        hold_up_nx  = up_only;
        hold_cnt_nx = CNT_W'(1);
      end else if (hold_act && hold_same) begin
        hold_act_nx = 1'b1;
        if (hold_hit) begin
          hold_rep_nx = 1'b1;
          hold_cnt_nx = CNT_W'(1);
        end else begin
          hold_rep_nx = hold_rep;
          hold_cnt_nx = hold_cnt + CNT_W'(1);
        end
      end
    end

    // Idle timer counts button-free cycles in set states only
    if (in_set && !any_btn && !idle_expire) begin
      idle_cnt_nx = idle_cnt + CNT_W'(1);
    end

    // Blink restarts high on entry and after each step, then toggles
    if (state_nx != state) begin
      blink_nx = (state_nx != RUN);
    end else if (in_set) begin
      if (step) begin
        blink_nx = 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
        blink_nx = ~blink;
      end else begin
        blink_nx     = blink;
        blink_cnt_nx = blink_cnt + CNT_W'(1);
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      hold_act  <= 1'b0;
      hold_up   <= 1'b0;
      hold_rep  <= 1'b0;
      hold_cnt  <= '0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
      sel       <= 4'b0000;
      c         <= 1'b0;
      cu        <= 1'b0;
      cd        <= 1'b0;
      setting   <= 1'b0;
      blink     <= 1'b0;
    end else begin
      mode_q    <= btn_mode;
      up_q      <= btn_up;
      dn_q      <= btn_down;
      hold_act  <= hold_act_nx;
      hold_up   <= hold_up_nx;
      hold_rep  <= hold_rep_nx;
      hold_cnt  <= hold_cnt_nx;
      idle_cnt  <= idle_cnt_nx;
      blink_cnt <= blink_cnt_nx;
      sel       <= sel_nx;
      c         <= c_nx;
      cu        <= cu_nx;
      cd        <= cd_nx;
      setting   <= setting_nx;
      blink     <= blink_nx;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl using default timing parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_up, btn_down;
  logic [3:0] sel;
  logic       c, cu, cd, setting, blink;

  int errors = 0;
  int checks = 0;
  int c_cnt, cu_cnt, cd_cnt, blink_ones;
  int steps[$];
  int exp_steps[4] = '{1, 501, 601, 701};
  logic [3:0] exp_sel[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .sel(sel), .c(c), .cu(cu), .cd(cd),
    .setting(setting), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    c_cnt = 0; cu_cnt = 0; cd_cnt = 0; blink_ones = 0;
    steps.delete();
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic run(input int n, input int base);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (c === 1'b1) begin c_cnt++; steps.push_back(base + i); end
      if (cu === 1'b1) cu_cnt++;
      if (cd === 1'b1) cd_cnt++;
      if (blink === 1'b1) blink_ones++;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    run(1, 0);
    btn_mode = 1'b0;
    run(1, 0);
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    #23;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_setting", 32'(setting), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(2, 0);

    // Mode cycling through all fields back to RUN
    clr();
    for (int i = 0; i < 5; i++) begin
      btn_mode = 1'b1;
      run(1, 0);
      check($sformatf("mode_sel%0d", i), 32'(sel), 32'(exp_sel[i]));
      check($sformatf("mode_setting%0d", i), 32'(setting), (i < 4) ? 32'd1 : 32'd0);
      btn_mode = 1'b0;
      run(1, 0);
    end
    check("mode_no_c", 32'(c_cnt), 32'd0);

    // Single step in T_MIN with a 3-cycle up press
    press_mode();
    press_mode();
    check("tmin_sel", 32'(sel), 32'b0010);
    clr();
    btn_up = 1'b1;
    run(1, 0);
    check("step_c", 32'(c), 32'd1);
    check("step_cu", 32'(cu), 32'd1);
    check("step_cd", 32'(cd), 32'd0);
    run(2, 1);
    btn_up = 1'b0;
    run(247, 3);
    check("step_count", 32'(c_cnt), 32'd1);
    check("step_cu_count", 32'(cu_cnt), 32'd1);
    check("step_blink_held", 32'(blink_ones), 32'd250);
    run(1, 250);
    check("step_blink_drop", 32'(blink), 32'd0);

    // Auto-repeat in T_HR holding down for 800 cycles
    for (int i = 0; i < 4; i++) press_mode();
    check("thr_sel", 32'(sel), 32'b0001);
    clr();
    btn_down = 1'b1;
    run(800, 0);
    btn_down = 1'b0;
    run(100, 800);
    check("rep_count", 32'(steps.size()), 32'd4);
    for (int i = 0; i < 4 && i < steps.size(); i++)
      check($sformatf("rep_pos%0d", i), 32'(steps[i]), 32'(exp_steps[i]));
    check("rep_cd_count", 32'(cd_cnt), 32'd4);
    check("rep_cu_count", 32'(cu_cnt), 32'd0);

    // Conflict: both held, then release one; no step at any point
    clr();
    btn_up = 1'b1; btn_down = 1'b1;
    run(1000, 0);
    btn_down = 1'b0;
    run(600, 0);
    btn_up = 1'b0;
    run(2, 0);
    check("conflict_no_c", 32'(c_cnt), 32'd0);

    // Priority: up and mode in the same cycle, up kept held
    clr();
    btn_up = 1'b1; btn_mode = 1'b1;
    run(1, 0);
    check("prio_c", 32'(c), 32'd0);
    check("prio_sel", 32'(sel), 32'b0010);
    btn_mode = 1'b0;
    run(600, 0);
    check("prio_no_repeat", 32'(c_cnt), 32'd0);
    btn_up = 1'b0;
    run(2, 0);

    // Idle timeout in A_HR, restarted by a press at idle cycle 9999
    btn_mode = 1'b1;
    run(1, 0);
    check("ahr_sel", 32'(sel), 32'b0100);
    btn_mode = 1'b0;
    run(9998, 0);
    check("idle_pre_press", 32'(sel), 32'b0100);
    btn_up = 1'b1;
    run(1, 0);
    btn_up = 1'b0;
    run(9999, 0);
    check("idle_not_yet_sel", 32'(sel), 32'b0100);
    check("idle_not_yet_setting", 32'(setting), 32'd1);
    run(1, 0);
    check("idle_sel", 32'(sel), 32'd0);
    check("idle_setting", 32'(setting), 32'd0);
    check("idle_blink", 32'(blink), 32'd0);

    // Asynchronous reset while auto-repeat is active
    press_mode();
    clr();
    btn_up = 1'b1;
    run(601, 0);
    check("hold_c_before_rst", 32'(c), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_c", 32'(c), 32'd0);
    check("arst_cu", 32'(cu), 32'd0);
    check("arst_setting", 32'(setting), 32'd0);
    check("arst_blink", 32'(blink), 32'd0);
    run(3, 0);
    rst = 1'b0;
    clr();
    run(600, 0);
    check("post_rst_no_c", 32'(c_cnt), 32'd0);
    check("post_rst_sel", 32'(sel), 32'd0);
    check("post_rst_setting", 32'(setting), 32'd0);
    btn_up = 1'b0;
    run(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
